// File: rtl/atmega_tim_pkg.sv
// Shared definitions for the ATmega timer cluster.
// Holds the GTCCR bit positions, the default GTCCR IO address, the prescaler
// tap positions and the helpers that decode prescaler strobes from a chain
// counter. Every timer in the cluster imports this package.
package atmega_tim_pkg;

  // GTCCR bit positions
  localparam int GTCCR_TSM     = 7;
  localparam int GTCCR_PSRASY  = 1;
  localparam int GTCCR_PSRSYNC = 0;

  localparam int GTCCR_ADDR_DEFAULT = 'h23;

  // Each prescaler chain is a free-running counter of this width
  localparam int CHAIN_WIDTH = 10;

  // Tap = log2(division ratio)
  localparam int TAP_CLK8    = 3;
  localparam int TAP_CLK32   = 5;
  localparam int TAP_CLK64   = 6;
  localparam int TAP_CLK128  = 7;
  localparam int TAP_CLK256  = 8;
  localparam int TAP_CLK1024 = 10;

  // Chain 0 is the timer0/timer1 chain, chain 1 is the timer2 chain
  localparam int SYNC_TAPS = 4;
  localparam int T2_TAPS   = 6;

  // Tap position of strobe 'idx' of a chain, lowest division ratio first
  function automatic int chain_tap(input int chain, input int idx);
    int tap;
    tap = TAP_CLK1024;
    if (chain == 0) begin
      case (idx)
        0:       tap = TAP_CLK8;
        1:       tap = TAP_CLK64;
        2:       tap = TAP_CLK256;
        default: tap = TAP_CLK1024;
      endcase
    end else begin
      case (idx)
        0:       tap = TAP_CLK8;
        1:       tap = TAP_CLK32;
        2:       tap = TAP_CLK64;
        3:       tap = TAP_CLK128;
        4:       tap = TAP_CLK256;
        default: tap = TAP_CLK1024;
      endcase
    end
    return tap;
  endfunction

  // True when the low 'tap' bits of the counter are all ones, i.e. the
  // counter is on the last count of a divide-by-2^tap period.
  // The mask is built one bit wider so a full-width tap does not overflow.
  function automatic logic tap_hit(input logic [CHAIN_WIDTH-1:0] cnt,
                                   input int tap);
    logic [CHAIN_WIDTH:0] mask;
    mask = (11'd1 << tap) - 11'd1;
    return ({1'b0, cnt} & mask) == mask;
  endfunction

endpackage

// File: rtl/atmega_pin_edge_sync.sv
// Synchroniser and edge detector for one asynchronous timer count pin.
// Ports:
//   clk, rst   core clock, synchronous active-high reset
//   pin        asynchronous external count pin
//   rise/fall  one-clk-wide strobes, SYNC_STAGES+1 edges after the pin moves
module atmega_pin_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic pin,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   synced;

  assign synced = sync_q[SYNC_STAGES-1];

  // prev_q lags the synchronised level by one edge, so each level change
  // yields exactly one strobe cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pin};
      prev_q <= synced;
      rise   <= synced & ~prev_q;
      fall   <= ~synced & prev_q;
    end
  end

endmodule

// File: rtl/atmega_tim_prescaler.sv
// Shared clock-source block for the ATmega timer cluster.
// Owns GTCCR (TSM, PSRASY, PSRSYNC), runs the timer0/timer1 prescaler chain
// and the timer2 prescaler chain, and synchronises the T0/T1 count pins.
// Ports:
//   clk, rst                 core clock, synchronous active-high reset
//   addr_io, wr_io, rd_io    IO bus address and strobes
//   bus_io_in / bus_io_out   IO write data / combinational read data
//   t0, t1                   asynchronous external count pins
//   clk8..clk1024            timer0/timer1 prescaler strobes
//   t2_clk8..t2_clk1024      timer2 prescaler strobes (0 when not built)
//   t0_rise..t1_fall         synchronised pin-edge strobes
// All strobe outputs are one clk wide.
module atmega_tim_prescaler
  import atmega_tim_pkg::*;
#(
  parameter int BUS_ADDR_IO_LEN  = 6,
  parameter int GTCCR_ADDR       = GTCCR_ADDR_DEFAULT,
  parameter     USE_T2_PRESCALER = "TRUE",
  parameter int SYNC_STAGES      = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [BUS_ADDR_IO_LEN-1:0] addr_io,
  input  logic                       wr_io,
  input  logic                       rd_io,
  input  logic [7:0]                 bus_io_in,
  output logic [7:0]                 bus_io_out,
  input  logic                       t0,
  input  logic                       t1,
  output logic                       clk8,
  output logic                       clk64,
  output logic                       clk256,
  output logic                       clk1024,
  output logic                       t2_clk8,
  output logic                       t2_clk32,
  output logic                       t2_clk64,
  output logic                       t2_clk128,
  output logic                       t2_clk256,
  output logic                       t2_clk1024,
  output logic                       t0_rise,
  output logic                       t0_fall,
  output logic                       t1_rise,
  output logic                       t1_fall
);

  localparam bit T2_EN    = (USE_T2_PRESCALER == "TRUE");
  localparam int N_CHAINS = T2_EN ? 2 : 1;
  localparam logic [BUS_ADDR_IO_LEN-1:0] GTCCR_ADDR_W = BUS_ADDR_IO_LEN'(GTCCR_ADDR);

  logic       tsm_q;
  logic [1:0] psr_q;       // indexed like GTCCR: [0] PSRSYNC, [1] PSRASY
  logic       gtccr_sel;
  logic       gtccr_wr;
  logic [SYNC_TAPS-1:0] sync_stb;
  logic [T2_TAPS-1:0]   t2_stb;
  logic       unused_wdata;

  assign gtccr_sel    = (addr_io == GTCCR_ADDR_W);
  assign gtccr_wr     = wr_io && gtccr_sel;
  assign unused_wdata = ^bus_io_in[6:2];

  // With TSM clear the PSR bits behave as self-clearing one-shots; with TSM
  // set they stick and keep their chain parked until software clears them.
  always_ff @(posedge clk) begin
    if (rst) begin
      tsm_q <= 1'b0;
      psr_q <= '0;
    end else if (gtccr_wr) begin
      tsm_q <= bus_io_in[GTCCR_TSM];
      psr_q <= {bus_io_in[GTCCR_PSRASY], bus_io_in[GTCCR_PSRSYNC]};
    end else if (!tsm_q) begin
      psr_q <= '0;
    end
  end

  always_comb begin
    bus_io_out = 8'h00;
    if (!rst && rd_io && gtccr_sel) begin
      bus_io_out[GTCCR_TSM]     = tsm_q;
      bus_io_out[GTCCR_PSRASY]  = psr_q[1];
      bus_io_out[GTCCR_PSRSYNC] = psr_q[0];
    end
  end

  // One prescaler chain per generate iteration. Chain ch is reset by a write
  // of 1 to GTCCR bit ch, or held while TSM and that PSR bit are both set.
  // A restart beats the wrap decode, so no strobe follows a cleared cycle.
  for (genvar ch = 0; ch < N_CHAINS; ch++) begin : g_chain
    localparam int N_TAPS = (ch == 0) ? SYNC_TAPS : T2_TAPS;

    logic [CHAIN_WIDTH-1:0] cnt_q;
    logic [N_TAPS-1:0]      stb_q;
    logic                   restart;

    assign restart = (gtccr_wr && bus_io_in[ch]) || (tsm_q && psr_q[ch]);

    always_ff @(posedge clk) begin
      if (rst || restart) begin
        cnt_q <= '0;
        stb_q <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
        for (int i = 0; i < N_TAPS; i++) begin
          stb_q[i] <= tap_hit(cnt_q, chain_tap(ch, i));
        end
      end
    end

    if (ch == 0) begin : g_sync_out
      assign sync_stb = stb_q;
    end else begin : g_t2_out
      assign t2_stb = stb_q;
    end
  end

  if (!T2_EN) begin : g_t2_off
    assign t2_stb = '0;
  end

  assign {clk1024, clk256, clk64, clk8} = sync_stb;
  assign {t2_clk1024, t2_clk256, t2_clk128, t2_clk64, t2_clk32, t2_clk8} = t2_stb;

  atmega_pin_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_t0_sync (
    .clk  (clk),
    .rst  (rst),
    .pin  (t0),
    .rise (t0_rise),
    .fall (t0_fall)
  );

  atmega_pin_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_t1_sync (
    .clk  (clk),
    .rst  (rst),
    .pin  (t1),
    .rise (t1_rise),
    .fall (t1_fall)
  );

endmodule

// File: tb/tb_atmega_tim_prescaler.sv
// Self-checking bench for atmega_tim_prescaler. Drives directed scenarios and
// random bus/pin traffic into a default instance and a USE_T2_PRESCALER="FALSE"
// instance, comparing both against a behavioural model that counts advances
// since the last prescaler clear and divides by the strobe ratios.
module tb_atmega_tim_prescaler;

  localparam int SS = 2;
  localparam logic [5:0] GTCCR_A = 6'h23;
  localparam int SYNC_N[4] = '{8, 64, 256, 1024};
  localparam int T2_N[6]   = '{8, 32, 64, 128, 256, 1024};

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] addr_io = '0;
  logic       wr_io = 1'b0;
  logic       rd_io = 1'b0;
  logic [7:0] bus_io_in = '0;
  logic       t0 = 1'b0;
  logic       t1 = 1'b0;

  logic [7:0] bus_io_out;
  logic clk8, clk64, clk256, clk1024;
  logic t2_clk8, t2_clk32, t2_clk64, t2_clk128, t2_clk256, t2_clk1024;
  logic t0_rise, t0_fall, t1_rise, t1_fall;

  logic [7:0] nt_bus_io_out;
  logic nt_clk8, nt_clk64, nt_clk256, nt_clk1024;
  logic nt_t2_clk8, nt_t2_clk32, nt_t2_clk64, nt_t2_clk128, nt_t2_clk256, nt_t2_clk1024;
  logic nt_t0_rise, nt_t0_fall, nt_t1_rise, nt_t1_fall;

  always #5 clk = ~clk;

  atmega_tim_prescaler u_dut (
    .clk(clk), .rst(rst), .addr_io(addr_io), .wr_io(wr_io), .rd_io(rd_io),
    .bus_io_in(bus_io_in), .bus_io_out(bus_io_out), .t0(t0), .t1(t1),
    .clk8(clk8), .clk64(clk64), .clk256(clk256), .clk1024(clk1024),
    .t2_clk8(t2_clk8), .t2_clk32(t2_clk32), .t2_clk64(t2_clk64),
    .t2_clk128(t2_clk128), .t2_clk256(t2_clk256), .t2_clk1024(t2_clk1024),
    .t0_rise(t0_rise), .t0_fall(t0_fall), .t1_rise(t1_rise), .t1_fall(t1_fall)
  );

  atmega_tim_prescaler #(.USE_T2_PRESCALER("FALSE")) u_dut_no_t2 (
    .clk(clk), .rst(rst), .addr_io(addr_io), .wr_io(wr_io), .rd_io(rd_io),
    .bus_io_in(bus_io_in), .bus_io_out(nt_bus_io_out), .t0(t0), .t1(t1),
    .clk8(nt_clk8), .clk64(nt_clk64), .clk256(nt_clk256), .clk1024(nt_clk1024),
    .t2_clk8(nt_t2_clk8), .t2_clk32(nt_t2_clk32), .t2_clk64(nt_t2_clk64),
    .t2_clk128(nt_t2_clk128), .t2_clk256(nt_t2_clk256), .t2_clk1024(nt_t2_clk1024),
    .t0_rise(nt_t0_rise), .t0_fall(nt_t0_fall), .t1_rise(nt_t1_rise), .t1_fall(nt_t1_fall)
  );

  // Reference model state
  bit         m_tsm;
  bit [1:0]   m_psr;
  longint     m_adv[2];          // advances since the chain was last cleared
  bit [3:0]   m_sync_stb;
  bit [5:0]   m_t2_stb;
  bit [SS+1:0] m_hist0, m_hist1; // pin samples, bit 0 = newest edge

  int check_count = 0;
  int fail_count  = 0;
  bit pin0 = 1'b0;
  bit pin1 = 1'b0;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    check_count++;
    if (obs !== exp) begin
      fail_count++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_edge(input bit r, input bit w, input bit [5:0] a,
                            input bit [7:0] d, input bit p0, input bit p1);
    bit wr_hit;
    if (r) begin
      m_tsm = 0; m_psr = '0; m_adv[0] = 0; m_adv[1] = 0;
      m_sync_stb = '0; m_t2_stb = '0; m_hist0 = '0; m_hist1 = '0;
      return;
    end
    wr_hit = w && (a == GTCCR_A);
    for (int ch = 0; ch < 2; ch++) begin
      if ((wr_hit && d[ch]) || (m_tsm && m_psr[ch])) begin
        m_adv[ch] = 0;
        if (ch == 0) m_sync_stb = '0; else m_t2_stb = '0;
      end else begin
        m_adv[ch] = m_adv[ch] + 1;
        if (ch == 0) for (int i = 0; i < 4; i++) m_sync_stb[i] = (m_adv[ch] % SYNC_N[i]) == 0;
        else         for (int i = 0; i < 6; i++) m_t2_stb[i]   = (m_adv[ch] % T2_N[i]) == 0;
      end
    end
    if (wr_hit) begin
      m_tsm = d[7];
      m_psr = d[1:0];
    end else if (!m_tsm) begin
      m_psr = '0;
    end
    m_hist0 = {m_hist0[SS:0], p0};
    m_hist1 = {m_hist1[SS:0], p1};
  endtask

  // One clock cycle: drive inputs, take the edge, update the model, compare
  task automatic applyStimulus(input bit r, input bit w, input bit rd, input bit [5:0] a,
                               input bit [7:0] d, input bit p0, input bit p1);
    logic [7:0] exp_rd;
    logic [3:0] exp_pin;
    rst = r; wr_io = w; rd_io = rd; addr_io = a; bus_io_in = d; t0 = p0; t1 = p1;
    @(posedge clk);
    model_edge(r, w, a, d, p0, p1);
    #1;
    exp_rd  = (!r && rd && a == GTCCR_A) ? {m_tsm, 5'b0, m_psr} : 8'h00;
    exp_pin = {m_hist1[SS] & ~m_hist1[SS+1], ~m_hist1[SS] & m_hist1[SS+1],
               m_hist0[SS] & ~m_hist0[SS+1], ~m_hist0[SS] & m_hist0[SS+1]};
    checkOutput("sync_stb", {clk1024, clk256, clk64, clk8}, m_sync_stb);
    checkOutput("t2_stb", {t2_clk1024, t2_clk256, t2_clk128, t2_clk64, t2_clk32, t2_clk8}, m_t2_stb);
    checkOutput("pin_stb", {t1_rise, t1_fall, t0_rise, t0_fall}, exp_pin);
    checkOutput("rd_data", bus_io_out, exp_rd);
    checkOutput("no_t2_sync", {nt_clk1024, nt_clk256, nt_clk64, nt_clk8}, m_sync_stb);
    checkOutput("no_t2_stb", {nt_t2_clk1024, nt_t2_clk256, nt_t2_clk128, nt_t2_clk64,
                              nt_t2_clk32, nt_t2_clk8}, 0);
    checkOutput("no_t2_rd", nt_bus_io_out, exp_rd);
  endtask

  task automatic run_idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 1, GTCCR_A, 8'h00, pin0, pin1);
  endtask

  task automatic write_gtccr(input bit [7:0] d);
    applyStimulus(0, 1, 1, GTCCR_A, d, pin0, pin1);
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1, 0, 0, 6'h00, 8'h00, pin0, pin1);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout, want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit [5:0] a;
    bit [7:0] d;
    bit r, w;

    // Free run from reset with random reads and pin activity
    do_reset(3);
    for (int k = 1; k <= 2100; k++) begin
      if ($urandom_range(0, 3) == 0) pin0 = ~pin0;
      if ($urandom_range(0, 3) == 0) pin1 = ~pin1;
      a = ($urandom_range(0, 1) == 1) ? GTCCR_A : 6'($urandom_range(0, 63));
      applyStimulus(0, 0, 1'($urandom_range(0, 1)), a, 8'($urandom), pin0, pin1);
      checkOutput("clk8_sched", clk8, (k % 8) == 0);
      checkOutput("clk64_sched", clk64, (k % 64) == 0);
      checkOutput("clk1024_sched", clk1024, (k % 1024) == 0);
      checkOutput("t2clk32_sched", t2_clk32, (k % 32) == 0);
    end

    // PSRSYNC one-shot with TSM clear
    pin0 = 0; pin1 = 0;
    do_reset(2);
    run_idle(100);
    write_gtccr(8'h01);
    checkOutput("psrsync_set_rd", bus_io_out, 8'h01);
    for (int j = 1; j <= 8; j++) begin
      run_idle(1);
      if (j == 1) checkOutput("psrsync_selfclear", bus_io_out, 8'h00);
      checkOutput("clk8_after_psr", clk8, j == 8);
    end

    // TSM hold of both chains, then release
    write_gtccr(8'h83);
    for (int j = 0; j < 50; j++) begin
      run_idle(1);
      checkOutput("hold_sync", {clk1024, clk256, clk64, clk8}, 0);
      checkOutput("hold_t2", {t2_clk1024, t2_clk256, t2_clk128, t2_clk64, t2_clk32, t2_clk8}, 0);
      checkOutput("hold_rd", bus_io_out, 8'h83);
    end
    write_gtccr(8'h00);
    checkOutput("release_rd", bus_io_out, 8'h00);
    for (int j = 1; j <= 8; j++) begin
      run_idle(1);
      checkOutput("release_clk8", clk8, j == 8);
      checkOutput("release_t2clk8", t2_clk8, j == 8);
    end

    // Pin pulse with 5-cycle levels on t0
    run_idle(5);
    for (int c = 0; c < 12; c++) begin
      pin0 = (c < 5);
      run_idle(1);
      checkOutput("t0_rise_lat", t0_rise, c == 2);
      checkOutput("t0_fall_lat", t0_fall, c == 7);
      checkOutput("t1_quiet", {t1_rise, t1_fall}, 0);
    end
    pin0 = 0;

    // Read masking, foreign address, and reset during a TSM hold
    write_gtccr(8'hFF);
    checkOutput("mask_rd", bus_io_out, 8'h83);
    applyStimulus(0, 0, 1, 6'h22, 8'h00, pin0, pin1);
    checkOutput("other_addr_rd", bus_io_out, 8'h00);
    run_idle(10);
    do_reset(1);
    checkOutput("rst_rd", bus_io_out, 8'h00);
    for (int k = 1; k <= 16; k++) begin
      run_idle(1);
      if (k == 1) checkOutput("rst_gtccr", bus_io_out, 8'h00);
      checkOutput("rst_clk8", clk8, (k % 8) == 0);
    end

    // Random traffic: register writes, reads, pins and occasional resets
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 2) == 0) pin0 = ~pin0;
      if ($urandom_range(0, 2) == 0) pin1 = ~pin1;
      r = ($urandom_range(0, 599) == 0);
      w = ($urandom_range(0, 29) == 0);
      a = ($urandom_range(0, 3) != 0) ? GTCCR_A : 6'($urandom_range(0, 63));
      d = 8'($urandom);
      applyStimulus(r, w, 1'($urandom_range(0, 1)), a, d, pin0, pin1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", check_count, fail_count);
    $finish;
  end

endmodule
